// File: rtl/raw_staging_buffer.sv
// raw_staging_buffer: small pool of staging slots. Each accepted entry waits
// out its own countdown, then is offered to the accumulator. The lowest-index
// due slot is presented first. An entry that arrives while every slot is busy
// is dropped and recorded in a sticky overflow flag.
module raw_staging_buffer #(
    parameter int NUM_SLOTS         = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 9,
    parameter int COUNTDOWN_WIDTH   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_valid,
    input  logic [DATA_WIDTH-1:0]              i_data,
    input  logic [PARTICLE_ID_WIDTH-1:0]       i_pid,
    input  logic [COUNTDOWN_WIDTH-1:0]         i_countdown,
    output logic                               o_in_ready,
    input  logic                               i_acc_ready,
    output logic [DATA_WIDTH-1:0]              o_data_to_acc,
    output logic [PARTICLE_ID_WIDTH-1:0]       o_pid_to_acc,
    output logic                               o_data_to_acc_valid,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     o_occupancy,
    output logic                               o_overflow
);

    localparam int OCC_W = $clog2(NUM_SLOTS + 1);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    logic [NUM_SLOTS-1:0]         vld_q, vld_d;
    logic [DATA_WIDTH-1:0]        data_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0]        data_d [NUM_SLOTS];
    logic [PARTICLE_ID_WIDTH-1:0] pid_q  [NUM_SLOTS];
    logic [PARTICLE_ID_WIDTH-1:0] pid_d  [NUM_SLOTS];
    logic [COUNTDOWN_WIDTH-1:0]   cnt_q  [NUM_SLOTS];
    logic [COUNTDOWN_WIDTH-1:0]   cnt_d  [NUM_SLOTS];
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic                         ovf_q, ovf_d;

    logic                         free_found, due_found;
    logic [IDX_W-1:0]             free_idx, due_idx;
    logic                         accept, release_w;

    // Find lowest-index free slot and lowest-index due slot (registered state only).
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        due_found  = 1'b0;
        due_idx    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (vld_q[i] && (cnt_q[i] == '0)) begin
                due_found = 1'b1;
                due_idx   = IDX_W'(i);
            end
        end
    end

    // A slot released this cycle is still valid in registered state, so the
    // free-slot search can never hand it to a same-cycle accept.
    assign o_in_ready          = free_found;
    assign accept              = i_valid && free_found;
    assign o_data_to_acc_valid = due_found;
    assign release_w           = due_found && i_acc_ready;
    assign o_data_to_acc       = due_found ? data_q[due_idx] : '0;
    assign o_pid_to_acc        = due_found ? pid_q[due_idx]  : '0;
    assign o_occupancy         = occ_q;
    assign o_overflow          = ovf_q;

    // Next state: count down waiting slots, retire the released slot, load the accepted entry.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        pid_d  = pid_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (vld_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - COUNTDOWN_WIDTH'(1);
            end
        end
        if (release_w) begin
            vld_d[due_idx] = 1'b0;
        end
        if (accept) begin
            vld_d[free_idx]  = 1'b1;
            data_d[free_idx] = i_data;
            pid_d[free_idx]  = i_pid;
            cnt_d[free_idx]  = i_countdown;
        end
        occ_d = occ_q;
        case ({accept, release_w})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        ovf_d = ovf_q || (i_valid && !free_found);
    end

    // State registers; reset clears every slot and both status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                data_q[i] <= '0;
                pid_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            pid_q  <= pid_d;
            cnt_q  <= cnt_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: doc/raw_staging_buffer.md
RAW_STAGING_BUFFER -- requirements
Module: raw_staging_buffer

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 4, meaning the number of staging slots (minimum 2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of the float data word.
REQ-003 The block SHALL have parameter PARTICLE_ID_WIDTH, default 9, meaning the width of the particle tag carried with the data.
REQ-004 The block SHALL have parameter COUNTDOWN_WIDTH, default 3, meaning the width of the per-entry hold countdown.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-007 The block SHALL have port i_valid, input, 1 bit: an input entry is offered.
REQ-008 The block SHALL have port i_data, input, DATA_WIDTH bits: the partial force value.
REQ-009 The block SHALL have port i_pid, input, PARTICLE_ID_WIDTH bits: the particle tag.
REQ-010 The block SHALL have port i_countdown, input, COUNTDOWN_WIDTH bits: the number of cycles to hold the entry before release.
REQ-011 The block SHALL have port o_in_ready, output, 1 bit: at least one slot is free.
REQ-012 The block SHALL have port i_acc_ready, input, 1 bit: the accumulator accepts an output this cycle.
REQ-013 The block SHALL have port o_data_to_acc, output, DATA_WIDTH bits: the released data.
REQ-014 The block SHALL have port o_pid_to_acc, output, PARTICLE_ID_WIDTH bits: the released tag.
REQ-015 The block SHALL have port o_data_to_acc_valid, output, 1 bit: the released data is valid.
REQ-016 The block SHALL have port o_occupancy, output, $clog2(NUM_SLOTS+1) bits: the number of valid slots.
REQ-017 The block SHALL have port o_overflow, output, 1 bit: a sticky flag indicating an entry was dropped.

Function
REQ-018 Each slot SHALL hold a valid bit, data, pid and countdown, all registered.
REQ-019 A slot SHALL be "due" when it is valid and its countdown equals 0.
REQ-020 Each cycle, every valid slot with countdown > 0 that was not loaded this cycle SHALL decrement its countdown by 1, regardless of i_valid.
REQ-021 Due slots SHALL hold their countdown at 0 and never wrap.
REQ-022 o_in_ready SHALL be 1 iff at least one slot is invalid in the current registered state, with no combinational dependence on i_acc_ready or i_valid.
REQ-023 Accept SHALL occur when i_valid && o_in_ready.
REQ-024 On accept, the lowest-index invalid slot SHALL load i_data, i_pid and i_countdown, and become valid at the next edge.
REQ-025 The loaded countdown SHALL be i_countdown unmodified.
REQ-026 When i_valid && !o_in_ready, the entry SHALL be dropped, o_overflow SHALL be set at the next edge, and o_overflow SHALL stay 1 until rst.
REQ-027 Output selection SHALL be combinational from registered state: the lowest-index due slot drives o_data_to_acc and o_pid_to_acc, with o_data_to_acc_valid = 1.
REQ-028 When no slot is due, o_data_to_acc_valid SHALL be 0 and o_data_to_acc and o_pid_to_acc SHALL be 0.
REQ-029 Release SHALL occur when o_data_to_acc_valid && i_acc_ready; the selected slot is invalidated at the next edge.
REQ-030 Due slots that are not released SHALL remain valid and be presented in later cycles in index order.
REQ-031 Latency: an entry accepted at edge t with countdown k and no contention SHALL be presented as o_data_to_acc_valid from cycle t+1+k.
REQ-032 A slot freed by release in cycle n SHALL NOT be reused by an accept in the same cycle n; it becomes available in cycle n+1.
REQ-033 o_occupancy SHALL be a registered count of valid slots, updated by +1 on accept, -1 on release, and unchanged on simultaneous accept and release.
REQ-034 o_occupancy SHALL never exceed NUM_SLOTS or underflow.
REQ-035 At most one accept and one release SHALL occur per cycle.

Reset
REQ-036 While rst = 1 at an edge, all slots SHALL become invalid with data, pid and countdown cleared to 0, and o_occupancy and o_overflow SHALL be cleared to 0.
REQ-037 During and after reset, o_data_to_acc_valid SHALL be 0, o_data_to_acc and o_pid_to_acc SHALL be 0, and o_in_ready SHALL be 1.
REQ-038 rst asserted mid-operation SHALL discard all pending entries without releasing them, and an entry offered in the reset cycle SHALL be ignored.

Verification
REQ-039 Single entry, countdown 2, i_acc_ready=1: accept data 0x3F800000 pid 5 -> valid out exactly 3 cycles after the accept edge carrying 0x3F800000/5; occupancy goes 1 then 0.
REQ-040 Fill: NUM_SLOTS=4, five back-to-back entries, countdown 7, i_acc_ready=0 -> o_in_ready falls after the fourth; the fifth is dropped; o_overflow=1 and stays 1; occupancy=4.
REQ-041 Contention: slots 0 and 1 both due in the same cycle, i_acc_ready=1 -> slot 0 is released first, slot 1 the next cycle; no data lost.
REQ-042 Backpressure: entry due, i_acc_ready=0 for 5 cycles -> o_data_to_acc_valid held at 1 with stable data; release on the first cycle i_acc_ready=1.
REQ-043 Full with simultaneous release: buffer full, one due, i_acc_ready=1, i_valid=1 -> the new entry is dropped (o_in_ready=0) and the slot is free the next cycle.
REQ-044 Reset mid-operation: 3 pending entries, assert rst for 1 cycle -> occupancy=0, no release ever appears, o_overflow=0, o_in_ready=1.
